// File: rtl/t2mi_i2c_pkg.sv
// Shared definitions for the I2C target register window.
// Holds the FSM state encoding, the R/W bit and ACK/NACK bit values, and
// the address-match helper used by the top-level FSM.
package t2mi_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACK    = 3'd2,
        ST_PTR    = 3'd3,
        ST_WR     = 3'd4,
        ST_RD     = 3'd5,
        ST_IGNORE = 3'd6
    } i2c_state_e;

    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

    // General call (address 0) is never claimed, even if TARGET_ADDR were 0.
    function automatic logic addr_hit(input logic [7:0] addr_byte,
                                      input logic [6:0] target);
        return (addr_byte[7:1] == target) && (addr_byte[7:1] != 7'd0);
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one asynchronous bus line.
// A 2-FF synchroniser feeds a stable-count filter: the filtered level only
// follows the synchronised input after it has disagreed with the current
// level for FILTER_LEN consecutive clk cycles. rise/fall pulse for one cycle,
// coincident with the first cycle of the new filtered level.
// Ports:
//   clk, rst_n  system clock, async active-low reset (line resets high = idle)
//   line_in     raw pin input
//   line_f      filtered level
//   rise, fall  1-cycle edge strobes of line_f
module i2c_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_f,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            line_f <= 1'b1;
            cnt_q  <= CNT_LOAD;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_in};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (sync_q[1] == line_f) begin
                cnt_q <= CNT_LOAD;
            end else if (cnt_q == '0) begin
                // Disagreement has lasted FILTER_LEN cycles: accept it.
                line_f <= sync_q[1];
                rise   <= sync_q[1];
                fall   <= ~sync_q[1];
                cnt_q  <= CNT_LOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 2**PTR_W byte register window to a host MCU.
// Runs on clk with no clock stretching; SDA is only ever pulled low.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   scl_in, sda_in    raw bus pins (asynchronous)
//   sda_oe            1 = pull SDA low
//   reg_addr          register index for reg_we / reg_re
//   reg_wdata         write data, valid with reg_we
//   reg_we, reg_re    1-cycle strobes; reg_rdata is sampled the cycle after reg_re
//   reg_rdata         read data from the register bank
//   bus_active        1 from any START to the next STOP
//
// state   | meaning
// IDLE    | bus free, waiting for START
// ADDR    | shifting in the address byte
// ACK     | driving ACK for the byte just received (ack_phase: 0 before, 1 during)
// PTR     | receiving the pointer byte
// WR      | receiving data bytes, one reg_we per byte
// RD      | transmitting bytes, bit_cnt 8 = released, 9 = awaiting host ACK
// IGNORE  | not addressed or host NACKed; hands off until START/STOP
module i2c_target_regs
    import t2mi_i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         PTR_W       = 4,
    parameter int         FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic [PTR_W-1:0] reg_addr,
    output logic [7:0]       reg_wdata,
    output logic             reg_we,
    output logic             reg_re,
    input  logic [7:0]       reg_rdata,
    output logic             bus_active
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_in(scl_in),
        .line_f (scl_f),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_in(sda_in),
        .line_f (sda_f),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    logic start_det, stop_det, byte_done;
    logic [7:0] rx_byte;

    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    i2c_state_e       state_q, state_d;
    i2c_state_e       ack_ret_q, ack_ret_d;
    logic             ack_phase_q, ack_phase_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       tx_q, tx_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] reg_addr_d;
    logic [7:0]       reg_wdata_d;
    logic             sda_oe_d, reg_we_d, reg_re_d, bus_active_d;
    logic             re_dly_q;

    // Full byte as it stands at the rising edge of its 8th bit.
    assign rx_byte   = {rx_q[6:0], sda_f};
    assign byte_done = scl_rise && (bit_cnt_q == 4'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = ST_ADDR;
        end else if (stop_det) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_ADDR: begin
                    if (byte_done) begin
                        state_d = addr_hit(rx_byte, TARGET_ADDR) ? ST_ACK : ST_IGNORE;
                    end
                end
                ST_ACK: begin
                    if (scl_fall && ack_phase_q) state_d = ack_ret_q;
                end
                ST_PTR, ST_WR: begin
                    if (byte_done) state_d = ST_ACK;
                end
                ST_RD: begin
                    if (scl_rise && (bit_cnt_q == 4'd9) && (sda_f == I2C_NACK)) begin
                        state_d = ST_IGNORE;
                    end
                end
                ST_IGNORE: state_d = ST_IGNORE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ack_ret_d    = ack_ret_q;
        ack_phase_d  = ack_phase_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        ptr_d        = ptr_q;
        sda_oe_d     = sda_oe;
        reg_addr_d   = reg_addr;
        reg_wdata_d  = reg_wdata;
        reg_we_d     = 1'b0;
        reg_re_d     = 1'b0;
        bus_active_d = bus_active;

        // Bank returns data the cycle after reg_re.
        if (re_dly_q) tx_d = reg_rdata;

        if (start_det) begin
            sda_oe_d     = 1'b0;
            bit_cnt_d    = 4'd0;
            ack_phase_d  = 1'b0;
            bus_active_d = 1'b1;
        end else if (stop_det) begin
            sda_oe_d     = 1'b0;
            bit_cnt_d    = 4'd0;
            bus_active_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        rx_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (byte_done) begin
                        bit_cnt_d   = 4'd0;
                        ack_phase_d = 1'b0;
                        if (addr_hit(rx_byte, TARGET_ADDR)) begin
                            ack_ret_d = (rx_byte[0] == I2C_RW_WRITE) ? ST_PTR : ST_RD;
                            if (rx_byte[0] == I2C_RW_READ) begin
                                reg_re_d   = 1'b1;
                                reg_addr_d = ptr_q;
                            end
                        end
                    end
                end
                ST_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = 4'd0;
                            sda_oe_d    = 1'b0;
                            // Read: the fall ending the ACK also launches the MSB.
                            if (ack_ret_q == ST_RD) begin
                                sda_oe_d  = ~tx_q[7];
                                tx_d      = {tx_q[6:0], 1'b0};
                                bit_cnt_d = 4'd1;
                            end
                        end
                    end
                end
                ST_PTR, ST_WR: begin
                    if (scl_rise) begin
                        rx_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (byte_done) begin
                        bit_cnt_d   = 4'd0;
                        ack_phase_d = 1'b0;
                        ack_ret_d   = ST_WR;
                        if (state_q == ST_PTR) begin
                            ptr_d = rx_byte[PTR_W-1:0];
                        end else begin
                            reg_we_d    = 1'b1;
                            reg_addr_d  = ptr_q;
                            reg_wdata_d = rx_byte;
                            ptr_d       = ptr_q + PTR_W'(1);
                        end
                    end
                end
                ST_RD: begin
                    if (scl_fall) begin
                        if (bit_cnt_q < 4'd8) begin
                            sda_oe_d  = ~tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end else if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd9;
                        end
                    end
                    if (scl_rise && (bit_cnt_q == 4'd9)) begin
                        // Pointer advances past the byte just sent, ACK or NACK.
                        ptr_d     = ptr_q + PTR_W'(1);
                        bit_cnt_d = 4'd0;
                        if (sda_f == I2C_ACK) begin
                            reg_re_d   = 1'b1;
                            reg_addr_d = ptr_q + PTR_W'(1);
                        end
                    end
                end
                ST_IGNORE: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_ret_q   <= ST_IDLE;
            ack_phase_q <= 1'b0;
            bit_cnt_q   <= 4'd0;
            rx_q        <= 8'd0;
            tx_q        <= 8'd0;
            ptr_q       <= '0;
            sda_oe      <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= 8'd0;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            bus_active  <= 1'b0;
            re_dly_q    <= 1'b0;
        end else begin
            ack_ret_q   <= ack_ret_d;
            ack_phase_q <= ack_phase_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            sda_oe      <= sda_oe_d;
            reg_addr    <= reg_addr_d;
            reg_wdata   <= reg_wdata_d;
            reg_we      <= reg_we_d;
            reg_re      <= reg_re_d;
            bus_active  <= bus_active_d;
            re_dly_q    <= reg_re;
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: an I2C host model with open-drain SDA,
// a read-only register bank model, and logging of reg_we / reg_re strobes.
module tb_i2c_target_regs;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_h = 1'b1;
    logic       sda_line;
    logic       sda_oe, reg_we, reg_re, bus_active;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;

    int n_assert = 0;
    int n_fail = 0;
    int tq = 625;

    logic [7:0] bank [16];
    logic [7:0] we_a [$];
    logic [7:0] we_d [$];
    logic [7:0] re_a [$];
    int oe_cnt = 0;
    int collisions = 0;

    assign sda_line = sda_h & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .bus_active(bus_active)
    );

    always @(posedge clk) begin
        if (reg_re) reg_rdata <= bank[reg_addr];
    end

    always @(negedge clk) begin
        if (reg_we) begin
            we_a.push_back(8'(reg_addr));
            we_d.push_back(reg_wdata);
        end
        if (reg_re) re_a.push_back(8'(reg_addr));
        if (sda_oe) oe_cnt++;
        if (reg_we && reg_re) collisions++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        sda_h = 1'b1; #(tq);
        scl = 1'b1;   #(tq);
        sda_h = 1'b0; #(tq);
        scl = 1'b0;   #(tq);
    endtask

    task automatic bus_stop();
        sda_h = 1'b0; #(tq);
        scl = 1'b1;   #(tq);
        sda_h = 1'b1; #(tq);
    endtask

    // glitch_bit >= 0 inserts an SCL low pulse of glitch_cyc clk cycles
    // in the middle of that bit's high phase.
    task automatic write_byte(input logic [7:0] b, input int glitch_bit,
                              input int glitch_cyc, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_h = b[i]; #(tq);
            scl = 1'b1;
            if (i == glitch_bit) begin
                #(tq);
                scl = 1'b0; #(glitch_cyc * 10);
                scl = 1'b1; #(tq - glitch_cyc * 10);
            end else begin
                #(2 * tq);
            end
            scl = 1'b0; #(tq);
        end
        sda_h = 1'b1; #(tq);
        scl = 1'b1;   #(tq);
        ack = sda_line; #(tq);
        scl = 1'b0;   #(tq);
    endtask

    task automatic read_byte(input logic host_ack, output logic [7:0] b);
        sda_h = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #(tq);
            scl = 1'b1; #(tq);
            b[i] = sda_line; #(tq);
            scl = 1'b0; #(tq);
        end
        sda_h = host_ack; #(tq);
        scl = 1'b1; #(2 * tq);
        scl = 1'b0; #(tq);
        sda_h = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         we_b, re_b, oe_b;

        for (int i = 0; i < 16; i++) bank[i] = 8'h00;
        bank[0] = 8'h81;
        bank[3] = 8'h5A;
        bank[4] = 8'h3C;
        bank[5] = 8'hC3;

        // Reset state
        rst_n = 1'b0;
        #22;
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_reg_re", reg_re, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_bus_active", bus_active, 0);
        rst_n = 1'b1;
        #200;

        // 1: write at 100 kHz: S,0x84,0x02,0xA5,P
        tq = 2500;
        we_b = we_a.size();
        bus_start();
        chk("t1_bus_active", bus_active, 1);
        write_byte(8'h84, -1, 0, ack); chk("t1_ack_addr", ack, 0);
        write_byte(8'h02, -1, 0, ack); chk("t1_ack_ptr", ack, 0);
        write_byte(8'hA5, -1, 0, ack); chk("t1_ack_data", ack, 0);
        bus_stop();
        chk("t1_bus_idle", bus_active, 0);
        chk("t1_we_count", we_a.size() - we_b, 1);
        if (we_a.size() > we_b) begin
            chk("t1_we_addr", we_a[we_b], 8'h02);
            chk("t1_we_data", we_d[we_b], 8'hA5);
        end
        // Pointer must now be 3: a plain read returns bank[3].
        tq = 625;
        re_b = re_a.size();
        bus_start();
        write_byte(8'h85, -1, 0, ack); chk("t1r_ack_addr", ack, 0);
        read_byte(1'b1, d);            chk("t1r_data", d, 8'h5A);
        bus_stop();
        chk("t1r_re_count", re_a.size() - re_b, 1);
        if (re_a.size() > re_b) chk("t1r_re_addr", re_a[re_b], 8'h03);

        // 2: pointer write then repeated-START read of two bytes
        re_b = re_a.size();
        we_b = we_a.size();
        bus_start();
        write_byte(8'h84, -1, 0, ack); chk("t2_ack_addr_w", ack, 0);
        write_byte(8'h04, -1, 0, ack); chk("t2_ack_ptr", ack, 0);
        bus_start();
        write_byte(8'h85, -1, 0, ack); chk("t2_ack_addr_r", ack, 0);
        read_byte(1'b0, d);            chk("t2_data0", d, 8'h3C);
        read_byte(1'b1, d);            chk("t2_data1", d, 8'hC3);
        chk("t2_sda_released", sda_oe, 0);
        bus_stop();
        chk("t2_re_count", re_a.size() - re_b, 2);
        if (re_a.size() > re_b + 1) begin
            chk("t2_re_addr0", re_a[re_b], 8'h04);
            chk("t2_re_addr1", re_a[re_b + 1], 8'h05);
        end
        chk("t2_we_count", we_a.size() - we_b, 0);

        // 3: wrong address
        we_b = we_a.size();
        oe_b = oe_cnt;
        bus_start();
        write_byte(8'hA0, -1, 0, ack); chk("t3_nack_addr", ack, 1);
        write_byte(8'h11, -1, 0, ack); chk("t3_nack_data", ack, 1);
        chk("t3_bus_active", bus_active, 1);
        bus_stop();
        chk("t3_bus_idle", bus_active, 0);
        chk("t3_oe_never", oe_cnt - oe_b, 0);
        chk("t3_we_count", we_a.size() - we_b, 0);

        // 4: pointer wrap 15 -> 0
        we_b = we_a.size();
        bus_start();
        write_byte(8'h84, -1, 0, ack); chk("t4_ack_addr", ack, 0);
        write_byte(8'h0F, -1, 0, ack); chk("t4_ack_ptr", ack, 0);
        write_byte(8'h11, -1, 0, ack); chk("t4_ack_d0", ack, 0);
        write_byte(8'h22, -1, 0, ack); chk("t4_ack_d1", ack, 0);
        bus_stop();
        chk("t4_we_count", we_a.size() - we_b, 2);
        if (we_a.size() > we_b + 1) begin
            chk("t4_we_addr0", we_a[we_b], 8'h0F);
            chk("t4_we_data0", we_d[we_b], 8'h11);
            chk("t4_we_addr1", we_a[we_b + 1], 8'h00);
            chk("t4_we_data1", we_d[we_b + 1], 8'h22);
        end

        // 5a: 3-cycle SCL glitches are filtered out
        we_b = we_a.size();
        bus_start();
        write_byte(8'h84, 4, 3, ack);  chk("t5_ack_addr", ack, 0);
        write_byte(8'h07, 2, 3, ack);  chk("t5_ack_ptr", ack, 0);
        write_byte(8'h99, -1, 0, ack); chk("t5_ack_data", ack, 0);
        bus_stop();
        chk("t5_we_count", we_a.size() - we_b, 1);
        if (we_a.size() > we_b) begin
            chk("t5_we_addr", we_a[we_b], 8'h07);
            chk("t5_we_data", we_d[we_b], 8'h99);
        end
        // 5b: a 5-cycle pulse is a real clock; MSB doubles, address becomes 0xC2
        oe_b = oe_cnt;
        bus_start();
        write_byte(8'h84, 7, 5, ack);  chk("t5b_nack", ack, 1);
        bus_stop();
        chk("t5b_oe_never", oe_cnt - oe_b, 0);

        // 6: reset while driving a 0 bit
        bus_start();
        write_byte(8'h84, -1, 0, ack); chk("t6_ack_addr_w", ack, 0);
        write_byte(8'h04, -1, 0, ack); chk("t6_ack_ptr", ack, 0);
        bus_start();
        write_byte(8'h85, -1, 0, ack); chk("t6_ack_addr_r", ack, 0);
        chk("t6_driving_zero", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_release", sda_oe, 0);
        scl = 1'b1;
        sda_h = 1'b1;
        #(tq);
        rst_n = 1'b1;
        #(2 * tq);
        chk("t6_bus_idle", bus_active, 0);
        re_b = re_a.size();
        bus_start();
        write_byte(8'h85, -1, 0, ack); chk("t6r_ack_addr", ack, 0);
        read_byte(1'b1, d);            chk("t6r_data", d, 8'h81);
        bus_stop();
        chk("t6r_re_count", re_a.size() - re_b, 1);
        if (re_a.size() > re_b) chk("t6r_re_addr", re_a[re_b], 8'h00);

        chk("we_re_exclusive", collisions, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
